refclk_div_gen: RTL and testbench
=================================

Name: refclk_div_gen

Overview:
Multi-channel reference-clock divider and gate generator in the main clock domain. Each channel produces a one-cycle strobe, a divide-by-two square wave of that strobe, and a mode-selected output. Each channel has a programmable divide ratio, an active-low gate and an output-select mode. New divide/mode settings take effect only on a period boundary, so no output period is truncated. It feeds clock enables to the sample-rate, timer and DAC-interface blocks.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
DIV_W, 8, width of the divide value; period = DIV+1 cycles
DIV_RST, 1, divide value loaded into every channel at reset
CH_W, $clog2(NUM_CH) (minimum 1), derived channel-index width; must not be overridden

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ceb  in  NUM_CH  per-channel gate, active-low; 1 freezes the channel
cfg_wr  in  1  single-cycle configuration write strobe
cfg_ch  in  CH_W  target channel of the write
cfg_div  in  DIV_W  divide value to write
cfg_mode  in  2  mode to write: 00 TOGGLE, 01 PULSE, 10/11 OFF
cfg_pend  out  NUM_CH  shadow config held, waiting for a boundary
strobe  out  NUM_CH  one-cycle pulse per completed period
div2  out  NUM_CH  toggles on each strobe
out_o  out  NUM_CH  TOGGLE: div2; PULSE: strobe; OFF: 0

Behaviour:
- Interface: one clock (clk); reset (reset_n) is asynchronous, active-low.
- All outputs are registered. No combinational path from any input to any output.
- Reset state, per channel:
  - active div = DIV_RST, active mode = OFF
  - cnt = 0, shadow cleared, cfg_pend = 0
  - strobe = 0, div2 = 0, out_o = 0
- Active channel: ceb = 0 and active mode != OFF.
- On each clk edge with the channel active:
  - cnt != div: cnt <= cnt+1, strobe <= 0.
  - cnt == div (terminal): cnt <= 0, strobe <= 1, div2 <= ~div2.
  - strobe is high for exactly one cycle, once per div+1 active cycles.
  - First strobe is visible after div+1 active edges from cnt = 0.
- div = 0: strobe high every active cycle; div2 toggles every cycle.
- cnt is DIV_W bits wide; no overflow is possible because it wraps at div.
- ceb = 1 (gated): cnt and div2 hold, strobe <= 0. Deasserting ceb resumes from the held cnt with no extra pulse.
- Mode OFF: cnt <= 0, div2 <= 0, strobe <= 0.
- Configuration write (cfg_wr = 1, cfg_ch < NUM_CH):
  - {cfg_div, cfg_mode} go into that channel's shadow and cfg_pend sets.
  - A second write while pending overwrites the shadow (last write wins).
  - cfg_ch >= NUM_CH: the write is ignored.
- Shadow apply:
  - Channel active: shadow moves to active on the channel's next terminal edge. That terminal pulse uses the OLD div; cnt restarts at 0 under the new div/mode; cfg_pend clears.
  - Channel inactive (ceb = 1 or mode OFF): shadow applies on the next edge; cfg_pend clears.
- Write in the same cycle as an apply on that channel: the apply consumes the old shadow. The new write becomes the shadow and cfg_pend stays 1.
- Mode change TOGGLE→PULSE at a boundary: div2 keeps toggling internally; out_o switches source on the applied boundary.
- Mode change to OFF at a boundary: the terminal strobe still fires; counters clear from the next edge.
- out_o is registered from next-state values, so it is cycle-aligned with strobe and div2.
- Reset asserted mid-operation: all state returns to reset values immediately; no pulse is emitted on release.

Decomposition:
- Package refclk_div_pkg:
  - mode enum: MODE_TOGGLE = 2'b00, MODE_PULSE = 2'b01, MODE_OFF = 2'b10; 2'b11 decodes as OFF
  - function returning CH_W from NUM_CH
- Sub-module refclk_div_chan: one channel (counter, shadow, apply logic, output registers), instantiated NUM_CH times by a generate loop.
- Top level: cfg_ch decode and range check only.

Test Plan:
- Reset, then write ch0 div=3 mode PULSE with ceb[0] = 0 -> ch0 inactive, so the write applies on the next edge; strobe[0] pulses every 4 cycles, first pulse 4 edges after apply; out_o[0] == strobe[0].
- ch1 div=0 TOGGLE -> div2[1]/out_o[1] toggle every cycle. Then write div=2 mid-period -> cfg_pend[1] = 1 until the next terminal edge; that pulse spacing is 1 cycle, then 3-cycle spacing; no short period.
- ch2 div=4 PULSE running; hold ceb[2] = 1 for 7 cycles at cnt=2 -> no strobe while gated, cnt holds at 2; next strobe 3 active edges after release.
- ch3 active, div=5: two writes (div=1, then div=7) before the boundary -> only div=7 applies; a write in the terminal cycle keeps cfg_pend = 1 for one more period.
- Write with cfg_ch = NUM_CH -> no channel state or cfg_pend changes.
- Assert reset_n low mid-period on all channels -> strobe/div2/out_o/cfg_pend = 0 asynchronously; after release all channels are OFF with div = DIV_RST.

Source files
------------

// File: rtl/refclk_div_pkg.sv
// Shared types and helpers for the reference-clock divider/gate generator.
package refclk_div_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_PULSE  = 2'b01,
        MODE_OFF    = 2'b10
    } mode_e;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // 2'b11 is folded onto OFF so only legal encodings are ever stored
    function automatic mode_e decode_mode(input logic [1:0] m);
        return m[1] ? MODE_OFF : mode_e'(m);
    endfunction

endpackage

// File: rtl/refclk_div_chan.sv
// One divider channel: period counter, shadow config with boundary apply,
// and registered strobe / div2 / mode-selected outputs.
module refclk_div_chan
    import refclk_div_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ceb,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [1:0]       wr_mode,
    output logic             cfg_pend,
    output logic             strobe,
    output logic             div2,
    output logic             out_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, sh_div_q, sh_div_d;
    mode_e            mode_q, mode_d, sh_mode_q, sh_mode_d;
    logic             pend_d, strobe_d, div2_d, out_d;
    logic             running, term, apply;

    always_comb begin
        running   = !ceb && (mode_q != MODE_OFF);
        term      = running && (cnt_q == div_q);
        apply     = cfg_pend && (term || !running);
        cnt_d     = cnt_q;
        div2_d    = div2;
        strobe_d  = 1'b0;
        div_d     = div_q;
        mode_d    = mode_q;
        sh_div_d  = sh_div_q;
        sh_mode_d = sh_mode_q;
        pend_d    = cfg_pend;
        out_d     = 1'b0;

        if (mode_q == MODE_OFF) begin
            cnt_d  = '0;
            div2_d = 1'b0;
        end else if (!ceb) begin
            if (term) begin
                cnt_d    = '0;
                strobe_d = 1'b1;
                div2_d   = ~div2;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        // The count also restarts on an idle-channel apply so a held count can
        // never sit above a smaller new divide value.
        if (apply) begin
            div_d  = sh_div_q;
            mode_d = sh_mode_q;
            cnt_d  = '0;
            pend_d = 1'b0;
        end

        // A write landing on an apply edge becomes the next shadow.
        if (wr) begin
            sh_div_d  = wr_div;
            sh_mode_d = decode_mode(wr_mode);
            pend_d    = 1'b1;
        end

        case (mode_d)
            MODE_TOGGLE: out_d = div2_d;
            MODE_PULSE:  out_d = strobe_d;
            default:     out_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            div_q     <= DIV_W'(DIV_RST);
            mode_q    <= MODE_OFF;
            sh_div_q  <= '0;
            sh_mode_q <= MODE_OFF;
            cfg_pend  <= 1'b0;
            strobe    <= 1'b0;
            div2      <= 1'b0;
            out_o     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            mode_q    <= mode_d;
            sh_div_q  <= sh_div_d;
            sh_mode_q <= sh_mode_d;
            cfg_pend  <= pend_d;
            strobe    <= strobe_d;
            div2      <= div2_d;
            out_o     <= out_d;
        end
    end

endmodule

// File: rtl/refclk_div_gen.sv
// Multi-channel reference-clock divider: decodes config writes onto an
// array of independent divider channels.
module refclk_div_gen
    import refclk_div_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int DIV_W   = 8,
    parameter  int DIV_RST = 1,
    localparam int CH_W    = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ceb,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [1:0]        cfg_mode,
    output logic [NUM_CH-1:0] cfg_pend,
    output logic [NUM_CH-1:0] strobe,
    output logic [NUM_CH-1:0] div2,
    output logic [NUM_CH-1:0] out_o
);

    logic              cfg_ok;
    logic [NUM_CH-1:0] ch_wr;

    // Explicit range check: with a non-power-of-two NUM_CH some indices exist
    assign cfg_ok = cfg_wr && (32'(cfg_ch) < 32'(NUM_CH));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_wr[i] = cfg_ok && (cfg_ch == CH_W'(i));

        refclk_div_chan #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .ceb      (ceb[i]),
            .wr       (ch_wr[i]),
            .wr_div   (cfg_div),
            .wr_mode  (cfg_mode),
            .cfg_pend (cfg_pend[i]),
            .strobe   (strobe[i]),
            .div2     (div2[i]),
            .out_o    (out_o[i])
        );
    end

endmodule

// File: tb/tb_refclk_div_gen.sv
// Directed bench for refclk_div_gen with hand-computed per-edge expectations.
module tb_refclk_div_gen;

    localparam int NUM_CH = 5;
    localparam int DIV_W  = 8;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NUM_CH-1:0] ceb;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [1:0]        cfg_mode;
    logic [NUM_CH-1:0] cfg_pend, strobe, div2, out_o;

    int n_chk = 0;
    int n_err = 0;

    refclk_div_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DIV_RST(1)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ceb      (ceb),
        .cfg_wr   (cfg_wr),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .cfg_pend (cfg_pend),
        .strobe   (strobe),
        .div2     (div2),
        .out_o    (out_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int dv, input logic [1:0] md);
        cfg_wr   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_div  = DIV_W'(dv);
        cfg_mode = md;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic want);
        n_chk++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
    endtask

    task automatic chkv(input string tag, input logic [NUM_CH-1:0] obs,
                        input logic [NUM_CH-1:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        ceb      = '0;
        cfg_wr   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        cfg_mode = 2'b00;
        #1;
        chkv("rst_strobe", strobe, '0);
        chkv("rst_div2", div2, '0);
        chkv("rst_out", out_o, '0);
        chkv("rst_pend", cfg_pend, '0);
        tick();
        tick();
        reset_n = 1'b1;

        // ch0: idle channel applies on the next edge, then PULSE every 4 cycles
        wr(0, 3, 2'b01);
        tick();
        cfg_wr = 1'b0;
        chk1("ch0_pend_set", cfg_pend[0], 1'b1);
        tick();
        chk1("ch0_pend_clr", cfg_pend[0], 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk1("ch0_strobe", strobe[0], (k % 4) == 3);
            chk1("ch0_out", out_o[0], (k % 4) == 3);
            chk1("ch0_div2", div2[0], (k >= 3) && (k < 7));
        end

        // ch1: div=0 TOGGLE, then a mid-period change to div=2
        wr(1, 0, 2'b00);
        tick();
        cfg_wr = 1'b0;
        tick();
        chk1("ch1_div2_apply", div2[1], 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk1("ch1_div2", div2[1], (k % 2) == 1);
            chk1("ch1_out", out_o[1], (k % 2) == 1);
            chk1("ch1_strobe", strobe[1], 1'b1);
        end
        wr(1, 2, 2'b00);
        tick();
        cfg_wr = 1'b0;
        chk1("ch1_pend_wr", cfg_pend[1], 1'b1);
        chk1("ch1_stb_wr", strobe[1], 1'b1);
        tick();
        chk1("ch1_pend_bnd", cfg_pend[1], 1'b0);
        chk1("ch1_stb_bnd", strobe[1], 1'b1);
        tick();
        chk1("ch1_stb_n1", strobe[1], 1'b0);
        tick();
        chk1("ch1_stb_n2", strobe[1], 1'b0);
        tick();
        chk1("ch1_stb_n3", strobe[1], 1'b1);

        // ch2: div=4 PULSE, gated for 7 cycles at cnt=2
        wr(2, 4, 2'b01);
        tick();
        cfg_wr = 1'b0;
        tick();
        tick();
        tick();
        chk1("ch2_pre_gate", strobe[2], 1'b0);
        ceb[2] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk1("ch2_gated", strobe[2], 1'b0);
        end
        ceb[2] = 1'b0;
        tick();
        chk1("ch2_rel1", strobe[2], 1'b0);
        tick();
        chk1("ch2_rel2", strobe[2], 1'b0);
        tick();
        chk1("ch2_rel3", strobe[2], 1'b1);
        tick();
        chk1("ch2_rel4", strobe[2], 1'b0);

        // ch3: div=5, two writes before the boundary, last one wins
        wr(3, 5, 2'b01);
        tick();
        cfg_wr = 1'b0;
        tick();
        wr(3, 1, 2'b01);
        tick();
        wr(3, 7, 2'b01);
        tick();
        cfg_wr = 1'b0;
        chk1("ch3_pend", cfg_pend[3], 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("ch3_wait_stb", strobe[3], 1'b0);
            chk1("ch3_wait_pend", cfg_pend[3], 1'b1);
        end
        tick();
        chk1("ch3_old_term", strobe[3], 1'b1);
        chk1("ch3_applied", cfg_pend[3], 1'b0);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk1("ch3_div7_gap", strobe[3], 1'b0);
        end
        tick();
        chk1("ch3_div7_term", strobe[3], 1'b1);

        // ch3: write coinciding with the apply edge keeps cfg_pend set
        wr(3, 2, 2'b01);
        tick();
        cfg_wr = 1'b0;
        chk1("ch3_pend_a", cfg_pend[3], 1'b1);
        repeat (6) tick();
        chk1("ch3_pre_term", strobe[3], 1'b0);
        wr(3, 3, 2'b01);
        tick();
        cfg_wr = 1'b0;
        chk1("ch3_term_wr_stb", strobe[3], 1'b1);
        chk1("ch3_term_wr_pend", cfg_pend[3], 1'b1);
        tick();
        tick();
        chk1("ch3_div2_gap", strobe[3], 1'b0);
        tick();
        chk1("ch3_div2_term", strobe[3], 1'b1);
        chk1("ch3_pend_b", cfg_pend[3], 1'b0);
        repeat (3) tick();
        chk1("ch3_div3_gap", strobe[3], 1'b0);
        tick();
        chk1("ch3_div3_term", strobe[3], 1'b1);

        // out-of-range channel indices are ignored
        wr(5, 0, 2'b00);
        tick();
        chkv("oor5_pend", cfg_pend, '0);
        wr(7, 0, 2'b00);
        tick();
        cfg_wr = 1'b0;
        chkv("oor7_pend", cfg_pend, '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("ch4_idle", out_o[4] | div2[4] | strobe[4], 1'b0);
        end

        // asynchronous reset mid-period with a pending write
        wr(3, 9, 2'b00);
        tick();
        cfg_wr = 1'b0;
        chkv("pre_rst_pend", cfg_pend, 5'b01000);
        #3;
        reset_n = 1'b0;
        #1;
        chkv("arst_strobe", strobe, '0);
        chkv("arst_div2", div2, '0);
        chkv("arst_out", out_o, '0);
        chkv("arst_pend", cfg_pend, '0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chkv("post_rst_strobe", strobe, '0);
            chkv("post_rst_out", out_o, '0);
        end
        chkv("post_rst_pend", cfg_pend, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
